// File: rtl/reg_file_scb_pkg.sv
// Shared pipeline constants for the register file and its scoreboard:
// default widths and the depth function used to size storage and busy vectors.
package reg_file_scb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_RD     = 2;

  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_scb_board.sv
// Register scoreboard: one busy bit per register plus a registered count of
// pending producers. Flush beats issue; issue beats a same-index write-back.
module reg_scoreboard
  import reg_file_scb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  localparam int DEPTH     = rf_depth(ADDR_WIDTH),
  localparam int CNT_W     = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                  issue_en_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic                  flush_i,
  output logic [DEPTH-1:0]      busy_o,
  output logic [CNT_W-1:0]      pending_cnt_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_ok;

  assign issue_ok = issue_en_i && !((ZERO_REG != 0) && (issue_addr_i == '0));

  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
    if (flush_i) busy_d = '0;
    else if (issue_ok) busy_d[issue_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Count tracks the busy vector it is registered alongside.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_scb.sv
// Multi-port register file with optional zero register, write-to-read
// forwarding and a busy-bit scoreboard for outstanding producers.
module reg_file_scb
  import reg_file_scb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         WRITE_ENABLE,
  input  logic [ADDR_WIDTH-1:0]        WRITE_ADDR,
  input  logic [DATA_WIDTH-1:0]        WRITE_DATA,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA,
  output logic [NUM_RD-1:0]            RD_BUSY,
  input  logic                         ISSUE_ENABLE,
  input  logic [ADDR_WIDTH-1:0]        ISSUE_ADDR,
  input  logic                         FLUSH,
  output logic [ADDR_WIDTH:0]          PENDING_CNT
);

  localparam int DEPTH = rf_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  wr_ok;

  assign wr_ok = WRITE_ENABLE && !((ZERO_REG != 0) && (WRITE_ADDR == '0));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (wr_ok) begin
      mem_q[WRITE_ADDR] <= WRITE_DATA;
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_scb (
    .clk_i        (CLK),
    .rst_ni       (RESET),
    .wr_en_i      (WRITE_ENABLE),
    .wr_addr_i    (WRITE_ADDR),
    .issue_en_i   (ISSUE_ENABLE),
    .issue_addr_i (ISSUE_ADDR),
    .flush_i      (FLUSH),
    .busy_o       (busy),
    .pending_cnt_o(PENDING_CNT)
  );

  // A forwarded write-back also hides the busy bit it is about to clear.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_zero;
    logic                  fwd;

    assign idx     = RD_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = (ZERO_REG != 0) && (idx == '0);
    assign fwd     = (BYPASS != 0) && wr_ok && (idx == WRITE_ADDR);

    assign RD_DATA[p*DATA_WIDTH +: DATA_WIDTH] =
      (!RESET || is_zero) ? '0 : (fwd ? WRITE_DATA : mem_q[idx]);
    assign RD_BUSY[p] = RESET && !is_zero && !fwd && busy[idx];
  end

endmodule
